// File: rtl/instr_mem_responder.sv
// instr_mem_responder: on-chip instruction RAM answering the fetch-stage
// request/grant/rvalid interface in order, with a fixed read latency, a
// bounded number of outstanding requests, a preload write port and a
// grant-stall input.
module instr_mem_responder #(
   parameter int unsigned           WORD_WIDTH      = 32,
   parameter int unsigned           MEM_DEPTH       = 1024,
   parameter int unsigned           READ_LATENCY    = 1,
   parameter int unsigned           MAX_OUTSTANDING = 2,
   parameter logic [WORD_WIDTH-1:0] NOOP_INSTR      = 32'h0000_0013,
   localparam int unsigned          ADDR_BITS       = $clog2(MEM_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  instr_req_i,
   input  logic [WORD_WIDTH-1:0] instr_addr_i,
   output logic                  instr_gnt_o,
   output logic                  instr_rvalid_o,
   output logic [WORD_WIDTH-1:0] instr_rdata_o,
   output logic                  instr_err_o,
   input  logic                  load_we_i,
   input  logic [ADDR_BITS-1:0]  load_addr_i,
   input  logic [WORD_WIDTH-1:0] load_wdata_i,
   input  logic                  gnt_stall_i
);

   localparam int unsigned         CNT_W      = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CNT_W-1:0]    CNT_MAX    = CNT_W'(MAX_OUTSTANDING);
   // One bit wider than the address so the byte limit itself is representable.
   localparam logic [WORD_WIDTH:0] ADDR_LIMIT = (WORD_WIDTH + 1)'(4 * MEM_DEPTH);

   logic [WORD_WIDTH-1:0]   mem [MEM_DEPTH];
   logic [READ_LATENCY-1:0] pipe_valid;
   logic [WORD_WIDTH-1:0]   pipe_data [READ_LATENCY];
   logic [READ_LATENCY-1:0] pipe_err;
   logic [CNT_W-1:0]        cnt;
   logic                    retiring;
   logic                    cnt_ok;
   logic                    req_err;
   logic [ADDR_BITS-1:0]    req_idx;

   // Grant decision and request address decode.
   always_comb begin
      retiring    = pipe_valid[READ_LATENCY-1];
      // A response leaving this cycle frees a slot, so a full counter may still grant.
      cnt_ok      = (cnt < CNT_MAX) | retiring;
      instr_gnt_o = instr_req_i & ~gnt_stall_i & ~load_we_i & cnt_ok;
      req_idx     = instr_addr_i[ADDR_BITS+1:2];
      req_err     = (instr_addr_i[1:0] != 2'b00) | ({1'b0, instr_addr_i} >= ADDR_LIMIT);
   end

   // Outstanding counter: +1 per grant, -1 per response, unchanged when both.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else begin
         case ({instr_gnt_o, retiring})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   // Valid shift pipeline; reset discards every in-flight response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe_valid <= '0;
      end else begin
         pipe_valid[0] <= instr_gnt_o;
         for (int unsigned i = 1; i < READ_LATENCY; i++) begin
            pipe_valid[i] <= pipe_valid[i-1];
         end
      end
   end

   // Data/err shift pipeline; the word is captured at the grant edge so later loads do not affect it.
   always_ff @(posedge clk) begin
      pipe_data[0] <= req_err ? NOOP_INSTR : mem[req_idx];
      pipe_err[0]  <= req_err;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
         pipe_data[i] <= pipe_data[i-1];
         pipe_err[i]  <= pipe_err[i-1];
      end
   end

   // Preload write port; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (load_we_i) begin
         mem[load_addr_i] <= load_wdata_i;
      end
   end

   // Response outputs, forced to zero whenever no response is presented.
   always_comb begin
      instr_rvalid_o = retiring;
      instr_rdata_o  = retiring ? pipe_data[READ_LATENCY-1] : '0;
      instr_err_o    = retiring & pipe_err[READ_LATENCY-1];
   end

endmodule

// File: tb/tb_instr_mem_responder.sv
// Scoreboard bench for instr_mem_responder: dut 0 uses defaults
// (latency 1, 2 outstanding), dut 1 uses latency 3, 2 outstanding.
module tb_instr_mem_responder;

   typedef struct {
      logic [31:0] data;
      logic        err;
      int unsigned cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic [1:0]  rst_n;
   logic [1:0]  req, stall, we, gnt, rvalid, err;
   logic [31:0] addr [2];
   logic [31:0] rdata [2];
   logic [9:0]  laddr [2];
   logic [31:0] lwdata [2];

   int unsigned cyc = 0;
   int          checks = 0;
   int          errors = 0;
   int unsigned max_cnt_b = 0;
   exp_t        sb0[$];
   exp_t        sb1[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   instr_mem_responder dut_a (
      .clk(clk), .rst_n(rst_n[0]),
      .instr_req_i(req[0]), .instr_addr_i(addr[0]), .instr_gnt_o(gnt[0]),
      .instr_rvalid_o(rvalid[0]), .instr_rdata_o(rdata[0]), .instr_err_o(err[0]),
      .load_we_i(we[0]), .load_addr_i(laddr[0]), .load_wdata_i(lwdata[0]),
      .gnt_stall_i(stall[0])
   );

   instr_mem_responder #(.READ_LATENCY(3), .MAX_OUTSTANDING(2)) dut_b (
      .clk(clk), .rst_n(rst_n[1]),
      .instr_req_i(req[1]), .instr_addr_i(addr[1]), .instr_gnt_o(gnt[1]),
      .instr_rvalid_o(rvalid[1]), .instr_rdata_o(rdata[1]), .instr_err_o(err[1]),
      .load_we_i(we[1]), .load_addr_i(laddr[1]), .load_wdata_i(lwdata[1]),
      .gnt_stall_i(stall[1])
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, got, want);
      end
   endtask

   task automatic push(input int d, input logic [31:0] data, input logic e_err);
      exp_t e;
      e.data = data;
      e.err  = e_err;
      e.cyc  = cyc;
      if (d == 0) sb0.push_back(e);
      else        sb1.push_back(e);
   endtask

   // Monitor: pops expected responses whenever a DUT presents rvalid.
   task automatic mon(input int d);
      exp_t        e;
      int unsigned lat;
      bit          empty;
      lat   = (d == 0) ? 1 : 3;
      empty = (d == 0) ? (sb0.size() == 0) : (sb1.size() == 0);
      checks++;
      if (rvalid[d]) begin
         if (empty) begin
            errors++;
            $display("FAIL unexpected_rvalid dut%0d: got rdata %h err %0b required no response",
                     d, rdata[d], err[d]);
         end else begin
            if (d == 0) e = sb0.pop_front();
            else        e = sb1.pop_front();
            if (rdata[d] !== e.data || err[d] !== e.err || (cyc - e.cyc) != lat) begin
               errors++;
               $display("FAIL resp dut%0d: got rdata %h err %0b lat %0d required rdata %h err %0b lat %0d",
                        d, rdata[d], err[d], cyc - e.cyc, e.data, e.err, lat);
            end
         end
      end else if (rdata[d] !== '0 || err[d] !== 1'b0) begin
         errors++;
         $display("FAIL idle_zero dut%0d: got rdata %h err %0b required 0 0", d, rdata[d], err[d]);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n[0]) mon(0);
      if (rst_n[1]) mon(1);
      if (int'(dut_b.cnt) > int'(max_cnt_b)) max_cnt_b = int'(dut_b.cnt);
   end

   task automatic load(input int d, input logic [9:0] a, input logic [31:0] data);
      we[d]     = 1'b1;
      laddr[d]  = a;
      lwdata[d] = data;
      @(posedge clk); #1;
      we[d] = 1'b0;
   endtask

   // Hold a request until granted; returns the number of cycles waited.
   task automatic do_req(input int d, input logic [31:0] a, input logic [31:0] data,
                         input logic e_err, output int waited);
      bit done;
      done    = 0;
      waited  = 0;
      req[d]  = 1'b1;
      addr[d] = a;
      while (!done) begin
         @(negedge clk);
         if (gnt[d]) begin
            push(d, data, e_err);
            done = 1;
         end else begin
            waited++;
            if (waited >= 40) begin
               checks++;
               errors++;
               $display("FAIL gnt_timeout dut%0d: got no grant for addr %h required grant", d, a);
               req[d] = 1'b0;
               done   = 1;
            end
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      int wsum;
      int n0;
      int exp_w[8] = '{0, 0, 1, 0, 1, 0, 1, 0};
      rst_n = 2'b00;
      req = '0; stall = '0; we = '0;
      for (int i = 0; i < 2; i++) begin
         addr[i] = '0; laddr[i] = '0; lwdata[i] = '0;
      end
      @(posedge clk); #1;
      check("reset_rvalid", {30'd0, rvalid}, 32'd0);
      check("reset_rdata_a", rdata[0], 32'd0);
      check("reset_gnt_noreq", {30'd0, gnt}, 32'd0);
      @(posedge clk); #1;
      rst_n = 2'b11;

      for (int i = 0; i < 4; i++) load(0, 10'(i), 32'hA0 + 32'(i));
      load(0, 10'd1023, 32'h5555_AAAA);
      for (int i = 0; i < 8; i++) load(1, 10'(i), 32'hB0 + 32'(i));
      idle(2);

      // Back-to-back reads.
      wsum = 0;
      for (int i = 0; i < 4; i++) begin
         do_req(0, 32'(i * 4), 32'hA0 + 32'(i), 1'b0, w);
         wsum += w;
      end
      req[0] = 1'b0;
      check("b2b_gnt_waits", 32'(wsum), 32'd0);
      idle(3);

      // Stall.
      stall[0] = 1'b1; req[0] = 1'b1; addr[0] = 32'h8; n0 = 0;
      repeat (3) begin
         @(negedge clk);
         if (!gnt[0]) n0++;
         @(posedge clk); #1;
      end
      check("stall_gnt_low", 32'(n0), 32'd3);
      stall[0] = 1'b0;
      @(negedge clk);
      check("stall_release_gnt", {31'd0, gnt[0]}, 32'd1);
      if (gnt[0]) push(0, 32'hA2, 1'b0);
      @(posedge clk); #1;
      req[0] = 1'b0;
      idle(3);

      // Load priority.
      we[0] = 1'b1; laddr[0] = 10'd5; lwdata[0] = 32'hDEAD_BEEF;
      req[0] = 1'b1; addr[0] = 32'h14;
      @(negedge clk);
      check("load_blocks_gnt", {31'd0, gnt[0]}, 32'd0);
      @(posedge clk); #1;
      we[0] = 1'b0;
      @(negedge clk);
      check("gnt_after_load", {31'd0, gnt[0]}, 32'd1);
      if (gnt[0]) push(0, 32'hDEAD_BEEF, 1'b0);
      @(posedge clk); #1;
      req[0] = 1'b0;
      idle(3);

      // Errors and last-word boundary.
      do_req(0, 32'h2, 32'h13, 1'b1, w);
      do_req(0, 32'h1000, 32'h13, 1'b1, w);
      do_req(0, 32'hFFC, 32'h5555_AAAA, 1'b0, w);
      req[0] = 1'b0;
      idle(3);

      // Outstanding limit on the latency-3 instance.
      for (int i = 0; i < 8; i++) begin
         do_req(1, 32'(i * 4), 32'hB0 + 32'(i), 1'b0, w);
         check($sformatf("outst_wait_%0d", i), 32'(w), 32'(exp_w[i]));
      end
      req[1] = 1'b0;
      idle(6);
      check("outst_max_cnt", max_cnt_b, 32'd2);

      // Reset mid-flight on the latency-3 instance.
      do_req(1, 32'h0, 32'hB0, 1'b0, w);
      do_req(1, 32'h4, 32'hB1, 1'b0, w);
      req[1] = 1'b0;
      @(posedge clk); #1;
      check("pre_reset_rvalid", {31'd0, rvalid[1]}, 32'd1);
      rst_n[1] = 1'b0;
      sb1.delete();
      #1;
      check("rst_rvalid", {31'd0, rvalid[1]}, 32'd0);
      check("rst_rdata", rdata[1], 32'd0);
      check("rst_err", {31'd0, err[1]}, 32'd0);
      @(posedge clk); #1;
      rst_n[1] = 1'b1;
      idle(6);
      do_req(1, 32'h1C, 32'hB7, 1'b0, w);
      req[1] = 1'b0;
      idle(6);

      check("sb0_drained", 32'(sb0.size()), 32'd0);
      check("sb1_drained", 32'(sb1.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
